// File: rtl/pr_north_axil_ctrl_slave.sv
// AXI4-Lite control responder for the NORTH PR kernel: HLS-style ap_ctrl
// register file, kernel start/done handshake and a registered level interrupt.
module pr_north_axil_ctrl_slave #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    axi_clk,
   input  logic                    axi_reset_n,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_LITE_awaddr,
   input  logic [2:0]              S_AXI_LITE_awprot,
   input  logic                    S_AXI_LITE_awvalid,
   output logic                    S_AXI_LITE_awready,
   input  logic [DATA_WIDTH-1:0]   S_AXI_LITE_wdata,
   input  logic [DATA_WIDTH/8-1:0] S_AXI_LITE_wstrb,
   input  logic                    S_AXI_LITE_wvalid,
   output logic                    S_AXI_LITE_wready,
   output logic [1:0]              S_AXI_LITE_bresp,
   output logic                    S_AXI_LITE_bvalid,
   input  logic                    S_AXI_LITE_bready,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_LITE_araddr,
   input  logic [2:0]              S_AXI_LITE_arprot,
   input  logic                    S_AXI_LITE_arvalid,
   output logic                    S_AXI_LITE_arready,
   output logic [DATA_WIDTH-1:0]   S_AXI_LITE_rdata,
   output logic [1:0]              S_AXI_LITE_rresp,
   output logic                    S_AXI_LITE_rvalid,
   input  logic                    S_AXI_LITE_rready,
   output logic                    ap_start,
   input  logic                    ap_done,
   input  logic                    ap_idle,
   input  logic                    ap_ready,
   output logic [63:0]             arg0,
   output logic [63:0]             arg1,
   output logic [31:0]             arg_len,
   output logic                    interrupt
);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;
   typedef struct packed {
      logic [ADDR_WIDTH-1:0]   addr;
      logic [DATA_WIDTH-1:0]   data;
      logic [DATA_WIDTH/8-1:0] strb;
   } wreq_t;

   wstate_t          wstate;
   rstate_t          rstate;
   wreq_t            wreq;
   logic             aw_held, w_held, rd_ctrl;
   logic             gie, auto_restart, done_sticky, ready_sticky;
   logic [1:0]       ier, isr;
   logic [DATA_WIDTH-1:0] rd_word;
   logic             commit, wr_hit, wr_en, rd_hit, ctrl_wr, isr_wr, rd_ctrl_done;
   logic [3:0]       wr_idx;
   logic             unused_ok;

   function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
      return (a[ADDR_WIDTH-1:6] == '0) && (a[5:2] <= 4'd8);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   assign commit       = (wstate == W_IDLE) && aw_held && w_held;
   assign wr_hit       = addr_hit(wreq.addr);
   assign wr_en        = commit && wr_hit;
   assign wr_idx       = wreq.addr[5:2];
   assign ctrl_wr      = wr_en && (wr_idx == 4'd0) && wreq.strb[0];
   assign isr_wr       = wr_en && (wr_idx == 4'd3) && wreq.strb[0];
   assign rd_hit       = addr_hit(S_AXI_LITE_araddr);
   assign rd_ctrl_done = S_AXI_LITE_rvalid && S_AXI_LITE_rready && rd_ctrl;
   assign unused_ok    = ^{S_AXI_LITE_awprot, S_AXI_LITE_arprot, S_AXI_LITE_araddr[1:0], wreq.addr[1:0]};

   // Write channel: AW and W are latched independently, committed together.
   always_ff @(posedge axi_clk) begin
      if (!axi_reset_n) begin
         wstate            <= W_IDLE;
         aw_held           <= 1'b0;
         w_held            <= 1'b0;
         wreq              <= '0;
         S_AXI_LITE_awready <= 1'b0;
         S_AXI_LITE_wready <= 1'b0;
         S_AXI_LITE_bvalid <= 1'b0;
         S_AXI_LITE_bresp  <= RESP_OKAY;
      end else begin
         case (wstate)
            W_IDLE: begin
               if (commit) begin
                  S_AXI_LITE_bvalid <= 1'b1;
                  S_AXI_LITE_bresp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
                  wstate            <= W_RESP;
               end else begin
                  if (!aw_held) begin
                     if (S_AXI_LITE_awvalid && S_AXI_LITE_awready) begin
                        aw_held            <= 1'b1;
                        wreq.addr          <= S_AXI_LITE_awaddr;
                        S_AXI_LITE_awready <= 1'b0;
                     end else S_AXI_LITE_awready <= 1'b1;
                  end
                  if (!w_held) begin
                     if (S_AXI_LITE_wvalid && S_AXI_LITE_wready) begin
                        w_held            <= 1'b1;
                        wreq.data         <= S_AXI_LITE_wdata;
                        wreq.strb         <= S_AXI_LITE_wstrb;
                        S_AXI_LITE_wready <= 1'b0;
                     end else S_AXI_LITE_wready <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (S_AXI_LITE_bready) begin
                  S_AXI_LITE_bvalid  <= 1'b0;
                  aw_held            <= 1'b0;
                  w_held             <= 1'b0;
                  S_AXI_LITE_awready <= 1'b1;
                  S_AXI_LITE_wready  <= 1'b1;
                  wstate             <= W_IDLE;
               end
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_word = '0;
      if (rd_hit) begin
         case (S_AXI_LITE_araddr[5:2])
            4'd0: rd_word = {24'd0, auto_restart, 3'd0, ready_sticky, ap_idle, done_sticky, ap_start};
            4'd1: rd_word = {31'd0, gie};
            4'd2: rd_word = {30'd0, ier};
            4'd3: rd_word = {30'd0, isr};
            4'd4: rd_word = arg0[31:0];
            4'd5: rd_word = arg0[63:32];
            4'd6: rd_word = arg1[31:0];
            4'd7: rd_word = arg1[63:32];
            4'd8: rd_word = arg_len;
            default: rd_word = '0;
         endcase
      end
   end

   // Read channel: data is captured at the AR handshake and held until taken.
   always_ff @(posedge axi_clk) begin
      if (!axi_reset_n) begin
         rstate             <= R_IDLE;
         rd_ctrl            <= 1'b0;
         S_AXI_LITE_arready <= 1'b0;
         S_AXI_LITE_rvalid  <= 1'b0;
         S_AXI_LITE_rdata   <= '0;
         S_AXI_LITE_rresp   <= RESP_OKAY;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (S_AXI_LITE_arvalid && S_AXI_LITE_arready) begin
                  S_AXI_LITE_rdata   <= rd_word;
                  S_AXI_LITE_rresp   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
                  rd_ctrl            <= rd_hit && (S_AXI_LITE_araddr[5:2] == 4'd0);
                  S_AXI_LITE_rvalid  <= 1'b1;
                  S_AXI_LITE_arready <= 1'b0;
                  rstate             <= R_DATA;
               end else S_AXI_LITE_arready <= 1'b1;
            end
            R_DATA: begin
               if (S_AXI_LITE_rready) begin
                  S_AXI_LITE_rvalid  <= 1'b0;
                  S_AXI_LITE_arready <= 1'b1;
                  rstate             <= R_IDLE;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   // Kernel control state; hardware set events take priority over bus clears/toggles.
   always_ff @(posedge axi_clk) begin
      if (!axi_reset_n) begin
         ap_start     <= 1'b0;
         auto_restart <= 1'b0;
         done_sticky  <= 1'b0;
         ready_sticky <= 1'b0;
         gie          <= 1'b0;
         ier          <= 2'b00;
         isr          <= 2'b00;
         arg0         <= '0;
         arg1         <= '0;
         arg_len      <= '0;
         interrupt    <= 1'b0;
      end else begin
         if (ctrl_wr && wreq.data[0]) ap_start <= 1'b1;
         else if (ap_ready && !auto_restart) ap_start <= 1'b0;
         if (ctrl_wr) auto_restart <= wreq.data[7];
         if (ap_done) done_sticky <= 1'b1;
         else if (rd_ctrl_done) done_sticky <= 1'b0;
         if (ap_ready) ready_sticky <= 1'b1;
         else if (rd_ctrl_done) ready_sticky <= 1'b0;
         if (wr_en && (wr_idx == 4'd1) && wreq.strb[0]) gie <= wreq.data[0];
         if (wr_en && (wr_idx == 4'd2) && wreq.strb[0]) ier <= wreq.data[1:0];
         isr[0] <= ap_done  | (isr_wr ? (isr[0] ^ wreq.data[0]) : isr[0]);
         isr[1] <= ap_ready | (isr_wr ? (isr[1] ^ wreq.data[1]) : isr[1]);
         if (wr_en) begin
            case (wr_idx)
               4'd4: arg0[31:0]  <= merge(arg0[31:0],  wreq.data, wreq.strb);
               4'd5: arg0[63:32] <= merge(arg0[63:32], wreq.data, wreq.strb);
               4'd6: arg1[31:0]  <= merge(arg1[31:0],  wreq.data, wreq.strb);
               4'd7: arg1[63:32] <= merge(arg1[63:32], wreq.data, wreq.strb);
               4'd8: arg_len     <= merge(arg_len,     wreq.data, wreq.strb);
               default: ;
            endcase
         end
         interrupt <= gie & |(ier & isr);
      end
   end
endmodule

// File: tb/tb_pr_north_axil_ctrl_slave.sv
// Bench for pr_north_axil_ctrl_slave: directed AXI-Lite traffic, a register-map
// model updated on each write response / read handshake, and literal spot checks.
module tb_pr_north_axil_ctrl_slave;
   logic        axi_clk = 0, axi_reset_n = 0;
   logic [11:0] awaddr = 0, araddr = 0;
   logic [2:0]  awprot = 0, arprot = 0;
   logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic [31:0] wdata = 0;
   logic [3:0]  wstrb = 0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata, arg_len;
   logic        ap_start, interrupt;
   logic        ap_done = 0, ap_idle = 1, ap_ready = 0;
   logic [63:0] arg0, arg1;

   always #5 axi_clk = ~axi_clk;

   pr_north_axil_ctrl_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
      .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
      .S_AXI_LITE_awaddr(awaddr), .S_AXI_LITE_awprot(awprot), .S_AXI_LITE_awvalid(awvalid),
      .S_AXI_LITE_awready(awready), .S_AXI_LITE_wdata(wdata), .S_AXI_LITE_wstrb(wstrb),
      .S_AXI_LITE_wvalid(wvalid), .S_AXI_LITE_wready(wready), .S_AXI_LITE_bresp(bresp),
      .S_AXI_LITE_bvalid(bvalid), .S_AXI_LITE_bready(bready), .S_AXI_LITE_araddr(araddr),
      .S_AXI_LITE_arprot(arprot), .S_AXI_LITE_arvalid(arvalid), .S_AXI_LITE_arready(arready),
      .S_AXI_LITE_rdata(rdata), .S_AXI_LITE_rresp(rresp), .S_AXI_LITE_rvalid(rvalid),
      .S_AXI_LITE_rready(rready), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
      .ap_ready(ap_ready), .arg0(arg0), .arg1(arg1), .arg_len(arg_len), .interrupt(interrupt));

   int n_pass = 0, n_total = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
   endtask

   // ---------------- register-map model ----------------
   logic [11:0] tx_addr = 0;
   logic [31:0] tx_data = 0;
   logic [3:0]  tx_strb = 0;
   logic [63:0] m_arg0 = 0, m_arg1 = 0;
   logic [31:0] m_len = 0, m_rdata = 0;
   logic [1:0]  m_ier = 0, m_isr = 0, m_rresp = 0, m_bresp = 0, tg;
   logic        m_gie = 0, m_start = 0, m_auto = 0, m_done = 0, m_rdy = 0, m_irq = 0, m_rd_ctrl = 0;
   logic        p_rst = 1, p_done = 0, p_rdy = 0, p_idle = 0, p_ar = 0, p_r = 0, p_bv = 0;
   logic [11:0] p_araddr = 0;
   logic        clr, wc, wr, n_irq, n_start;

   function automatic logic mapped(input logic [11:0] a);
      return a inside {12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018, 12'h01C, 12'h020};
   endfunction

   function automatic logic [31:0] bm(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      return {s[3] ? n[31:24] : o[31:24], s[2] ? n[23:16] : o[23:16],
              s[1] ? n[15:8]  : o[15:8],  s[0] ? n[7:0]   : o[7:0]};
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a, input logic idle);
      case (a)
         12'h000: return {24'd0, m_auto, 3'd0, m_rdy, idle, m_done, m_start};
         12'h004: return {31'd0, m_gie};
         12'h008: return {30'd0, m_ier};
         12'h00C: return {30'd0, m_isr};
         12'h010: return m_arg0[31:0];
         12'h014: return m_arg0[63:32];
         12'h018: return m_arg1[31:0];
         12'h01C: return m_arg1[63:32];
         12'h020: return m_len;
         default: return 32'd0;
      endcase
   endfunction

   // Inputs/outputs are settled mid-low-phase; snapshot what the next edge will see.
   always @(negedge axi_clk) begin
      #2;
      p_rst = !axi_reset_n; p_done = ap_done; p_rdy = ap_ready; p_idle = ap_idle;
      p_ar = arvalid && arready; p_araddr = araddr; p_r = rvalid && rready; p_bv = bvalid;
   end

   always @(posedge axi_clk) begin
      #1;
      wc = 1'b0;
      if (p_rst) begin
         m_arg0 = 0; m_arg1 = 0; m_len = 0; m_gie = 0; m_ier = 0; m_isr = 0; m_start = 0;
         m_auto = 0; m_done = 0; m_rdy = 0; m_irq = 0; m_rd_ctrl = 0;
      end else begin
         clr = p_r && m_rd_ctrl;
         if (p_ar) begin
            m_rdata = m_read(p_araddr, p_idle);
            m_rresp = mapped(p_araddr) ? 2'b00 : 2'b10;
            m_rd_ctrl = (p_araddr == 12'h000);
         end
         wc = bvalid && !p_bv;              // a write takes effect on the edge its response appears
         wr = wc && mapped(tx_addr);
         n_irq = m_gie & |(m_ier & m_isr);
         n_start = (wr && tx_addr == 12'h000 && tx_strb[0] && tx_data[0]) ? 1'b1 :
                   (p_rdy && !m_auto) ? 1'b0 : m_start;
         if (wr && tx_addr == 12'h000 && tx_strb[0]) m_auto = tx_data[7];
         m_start = n_start;
         m_done = p_done | (m_done & !clr);
         m_rdy  = p_rdy  | (m_rdy  & !clr);
         tg = (wr && tx_addr == 12'h00C && tx_strb[0]) ? tx_data[1:0] : 2'b00;
         m_isr = (m_isr ^ tg) | {p_rdy, p_done};
         if (wr && tx_addr == 12'h004 && tx_strb[0]) m_gie = tx_data[0];
         if (wr && tx_addr == 12'h008 && tx_strb[0]) m_ier = tx_data[1:0];
         if (wr) case (tx_addr)
            12'h010: m_arg0[31:0]  = bm(m_arg0[31:0],  tx_data, tx_strb);
            12'h014: m_arg0[63:32] = bm(m_arg0[63:32], tx_data, tx_strb);
            12'h018: m_arg1[31:0]  = bm(m_arg1[31:0],  tx_data, tx_strb);
            12'h01C: m_arg1[63:32] = bm(m_arg1[63:32], tx_data, tx_strb);
            12'h020: m_len         = bm(m_len,         tx_data, tx_strb);
            default: ;
         endcase
         m_irq = n_irq;
         if (wc) m_bresp = mapped(tx_addr) ? 2'b00 : 2'b10;
      end
      chk("m_arg0", arg0, m_arg0);
      chk("m_arg1", arg1, m_arg1);
      chk("m_arg_len", {32'd0, arg_len}, {32'd0, m_len});
      chk("m_ap_start", {63'd0, ap_start}, {63'd0, m_start});
      chk("m_interrupt", {63'd0, interrupt}, {63'd0, m_irq});
      if (wc) chk("m_bresp", {62'd0, bresp}, {62'd0, m_bresp});
      if (!p_rst && p_ar) chk("m_rvalid_after_ar", {63'd0, rvalid}, 64'd1);
      if (rvalid) begin
         chk("m_rdata", {32'd0, rdata}, {32'd0, m_rdata});
         chk("m_rresp", {62'd0, rresp}, {62'd0, m_rresp});
      end
   end

   // ---------------- stimulus ----------------
   task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_lag, input int w_lag, input int hold,
                            output logic [1:0] resp, output int lat);
      int cyc;
      bit aw_done, w_done, aw_hs, w_hs;
      cyc = 0; aw_done = 0; w_done = 0; lat = -1; resp = 2'b11;
      tx_addr = a; tx_data = d; tx_strb = s;
      @(negedge axi_clk);
      awaddr = a; wdata = d; wstrb = s;
      while (!(aw_done && w_done) && cyc < 50) begin
         if (!aw_done && cyc >= aw_lag) awvalid = 1;
         if (!w_done && cyc >= w_lag) wvalid = 1;
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(negedge axi_clk); cyc++;
         if (aw_hs) begin awvalid = 0; aw_done = 1; end
         if (w_hs)  begin wvalid = 0;  w_done = 1;  end
      end
      if (!(aw_done && w_done)) begin
         chk("aw_w_accept_timeout", 0, 1); awvalid = 0; wvalid = 0; return;
      end
      lat = 0;
      while (!bvalid && lat < 50) begin @(negedge axi_clk); lat++; end
      if (!bvalid) begin chk("bvalid_timeout", 0, 1); return; end
      resp = bresp;
      for (int i = 0; i < hold; i++) begin
         @(negedge axi_clk);
         chk("bvalid_held", {63'd0, bvalid}, 64'd1);
         chk("awready_low_in_resp", {63'd0, awready}, 64'd0);
         chk("bresp_stable", {62'd0, bresp}, {62'd0, resp});
      end
      bready = 1;
      @(negedge axi_clk);
      bready = 0;
      chk("bvalid_drop", {63'd0, bvalid}, 64'd0);
      chk("awready_reassert", {63'd0, awready}, 64'd1);
   endtask

   task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
      int cyc;
      cyc = 0; d = 32'hFFFF_FFFF; resp = 2'b11;
      @(negedge axi_clk);
      araddr = a; arvalid = 1;
      while (!arready && cyc < 50) begin @(negedge axi_clk); cyc++; end
      if (!arready) begin chk("arready_timeout", 0, 1); arvalid = 0; return; end
      @(negedge axi_clk);
      arvalid = 0;
      chk("rvalid_next_cycle", {63'd0, rvalid}, 64'd1);
      cyc = 0;
      while (!rvalid && cyc < 50) begin @(negedge axi_clk); cyc++; end
      if (!rvalid) begin chk("rvalid_timeout", 0, 1); return; end
      d = rdata; resp = rresp;
      rready = 1;
      @(negedge axi_clk);
      rready = 0;
   endtask

   task automatic pulse(input bit done);
      @(negedge axi_clk);
      if (done) ap_done = 1; else ap_ready = 1;
      @(negedge axi_clk);
      ap_done = 0; ap_ready = 0;
   endtask

   initial begin
      logic [31:0] rd, rd2;
      logic [1:0]  rr, rr2;
      int lat, lat2, cyc;
      repeat (3) @(negedge axi_clk);
      chk("rst_awready", {63'd0, awready}, 64'd0);
      chk("rst_arready", {63'd0, arready}, 64'd0);
      chk("rst_bvalid",  {63'd0, bvalid}, 64'd0);
      chk("rst_rvalid",  {63'd0, rvalid}, 64'd0);
      chk("rst_ap_start", {63'd0, ap_start}, 64'd0);
      axi_reset_n = 1;
      @(negedge axi_clk);
      chk("post_rst_awready", {63'd0, awready}, 64'd1);

      // argument registers, AW before / with / after W
      axi_write(12'h010, 32'hDEADBEEF, 4'hF, 0, 1, 0, rr, lat);
      chk("w010_bresp", {62'd0, rr}, 64'd0);
      chk("w010_lat", lat, 1);
      axi_write(12'h014, 32'h00000001, 4'hF, 0, 0, 0, rr, lat);
      chk("w014_lat", lat, 1);
      chk("arg0_val", arg0, 64'h00000001_DEADBEEF);
      axi_read(12'h010, rd, rr);
      chk("r010_data", {32'd0, rd}, 64'hDEADBEEF);
      chk("r010_resp", {62'd0, rr}, 64'd0);
      axi_write(12'h018, 32'h12345678, 4'hF, 2, 0, 0, rr, lat);
      chk("w018_wfirst_lat", lat, 1);
      chk("arg1_lo", arg1, 64'h12345678);

      // partial strobes and a stalled response
      axi_write(12'h020, 32'hFFFFFFFF, 4'h5, 0, 0, 5, rr, lat);
      chk("arg_len_strb", {32'd0, arg_len}, 64'h00FF00FF);

      // ap_start / auto_restart
      axi_write(12'h000, 32'h1, 4'hF, 0, 0, 0, rr, lat);
      chk("start_set", {63'd0, ap_start}, 64'd1);
      pulse(0);
      chk("start_clr_on_ready", {63'd0, ap_start}, 64'd0);
      axi_write(12'h000, 32'h81, 4'hF, 0, 0, 0, rr, lat);
      pulse(0);
      chk("start_kept_auto", {63'd0, ap_start}, 64'd1);
      axi_write(12'h000, 32'h0, 4'hF, 0, 0, 0, rr, lat);
      chk("start_write0_noeffect", {63'd0, ap_start}, 64'd1);
      pulse(0);
      chk("start_clr_auto_off", {63'd0, ap_start}, 64'd0);

      // ISR toggle, interrupt latency, sticky clear-on-read
      axi_read(12'h00C, rd, rr);
      chk("isr_ready_only", {32'd0, rd}, 64'h2);
      axi_write(12'h00C, 32'h2, 4'hF, 0, 0, 0, rr, lat);
      axi_read(12'h00C, rd, rr);
      chk("isr_toggled_clear", {32'd0, rd}, 64'h0);
      axi_write(12'h004, 32'h1, 4'hF, 0, 0, 0, rr, lat);
      axi_write(12'h008, 32'h1, 4'hF, 0, 0, 0, rr, lat);
      pulse(1);
      chk("irq_not_yet", {63'd0, interrupt}, 64'd0);
      @(negedge axi_clk);
      chk("irq_two_after", {63'd0, interrupt}, 64'd1);
      axi_read(12'h00C, rd, rr);
      chk("isr_done", {32'd0, rd}, 64'h1);
      axi_read(12'h000, rd, rr);
      chk("ctrl_first", {32'd0, rd}, 64'hE);
      axi_read(12'h000, rd, rr);
      chk("ctrl_second", {32'd0, rd}, 64'h4);
      axi_write(12'h00C, 32'h1, 4'hF, 0, 0, 0, rr, lat);
      chk("irq_cleared", {63'd0, interrupt}, 64'd0);

      // concurrent read and write of the same register
      fork
         axi_write(12'h01C, 32'hCAFEF00D, 4'hF, 0, 0, 0, rr2, lat2);
         axi_read(12'h01C, rd2, rr);
      join
      chk("concurrent_old", {32'd0, rd2}, 64'h0);
      axi_read(12'h01C, rd, rr);
      chk("arg1_hi", {32'd0, rd}, 64'hCAFEF00D);

      // unmapped accesses
      axi_read(12'h03C, rd, rr);
      chk("r03c_data", {32'd0, rd}, 64'h0);
      chk("r03c_resp", {62'd0, rr}, 64'h2);
      axi_write(12'h024, 32'hFFFFFFFF, 4'hF, 0, 0, 0, rr, lat);
      chk("w024_resp", {62'd0, rr}, 64'h2);
      axi_write(12'h110, 32'hFFFFFFFF, 4'hF, 0, 0, 0, rr, lat);
      chk("w110_resp", {62'd0, rr}, 64'h2);
      chk("arg0_unchanged", arg0, 64'h00000001_DEADBEEF);
      chk("arg_len_unchanged", {32'd0, arg_len}, 64'h00FF00FF);

      // reset while a response is pending
      tx_addr = 12'h018; tx_data = 32'hA5A5A5A5; tx_strb = 4'hF;
      @(negedge axi_clk);
      awaddr = 12'h018; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      @(negedge axi_clk);
      awvalid = 0; wvalid = 0;
      cyc = 0;
      while (!bvalid && cyc < 50) begin @(negedge axi_clk); cyc++; end
      chk("pre_rst_bvalid", {63'd0, bvalid}, 64'd1);
      axi_reset_n = 0;
      @(negedge axi_clk);
      axi_reset_n = 1;
      chk("rst_drop_bvalid", {63'd0, bvalid}, 64'd0);
      chk("rst_arg0", arg0, 64'd0);
      chk("rst_arg1", arg1, 64'd0);
      chk("rst_arg_len", {32'd0, arg_len}, 64'd0);
      chk("rst_irq", {63'd0, interrupt}, 64'd0);
      @(negedge axi_clk);
      chk("rst_awready_back", {63'd0, awready}, 64'd1);
      chk("rst_bvalid_low", {63'd0, bvalid}, 64'd0);
      axi_write(12'h020, 32'h5, 4'hF, 0, 0, 0, rr, lat);
      chk("post_rst_write", {32'd0, arg_len}, 64'h5);

      repeat (2) @(negedge axi_clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
